alu_operand_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of ALU_core.
- Captures a decoded RV32I instruction and resolves operand forwarding from the MEM and WB stages.
- Selects register, immediate or PC operands and translates opcode/funct3/funct7 into the 4-bit ALU op.
- Presents registered srca/srcb/alu_op to ALU_core behind a valid/ready handshake with stall and flush.

---
 rtl/alu_operand_stage_if.sv | 51 +++++
 rtl/alu_operand_stage.sv | 188 ++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - decode-to-ALU operand stage bus bundle
interface alu_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rd_addr;
    logic            fwd_mem_en;
    logic [RA_W-1:0] fwd_mem_rd;
    logic [XLEN-1:0] fwd_mem_data;
    logic            fwd_wb_en;
    logic [RA_W-1:0] fwd_wb_rd;
    logic [XLEN-1:0] fwd_wb_data;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic [3:0]      alu_op;
    logic [RA_W-1:0] ex_rd;
    logic [XLEN-1:0] ex_pc;
    logic            illegal;

    // Decode/hazard side: drives the instruction and forwarding, consumes results
    modport master (
        output flush, in_valid, opcode, funct3, funct7_5,
        output rs1_addr, rs2_addr, rs1_data, rs2_data, imm, pc, rd_addr,
        output fwd_mem_en, fwd_mem_rd, fwd_mem_data,
        output fwd_wb_en, fwd_wb_rd, fwd_wb_data, ex_ready,
        input  in_ready, ex_valid, srca, srcb, alu_op, ex_rd, ex_pc, illegal
    );

    // Operand stage side
    modport slave (
        input  flush, in_valid, opcode, funct3, funct7_5,
        input  rs1_addr, rs2_addr, rs1_data, rs2_data, imm, pc, rd_addr,
        input  fwd_mem_en, fwd_mem_rd, fwd_mem_data,
        input  fwd_wb_en, fwd_wb_rd, fwd_wb_data, ex_ready,
        output in_ready, ex_valid, srca, srcb, alu_op, ex_rd, ex_pc, illegal
    );
endinterface

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX stage: forwarding, operand select, ALU op decode
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    alu_operand_stage_if.slave bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    logic            ex_valid_q, ex_valid_d;
    logic [XLEN-1:0] srca_q, srca_d;
    logic [XLEN-1:0] srcb_q, srcb_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [RA_W-1:0] ex_rd_q, ex_rd_d;
    logic [XLEN-1:0] ex_pc_q, ex_pc_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [XLEN-1:0] dec_a, dec_b;
    logic [3:0]      dec_op;
    logic            dec_ill;

    // MEM is the younger producer, so it shadows WB; x0 is hardwired zero
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] rf_data,
        input logic            mem_en,
        input logic [RA_W-1:0] mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_en,
        input logic [RA_W-1:0] wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        if (addr == '0)                     return '0;
        else if (mem_en && mem_rd == addr)  return mem_data;
        else if (wb_en && wb_rd == addr)    return wb_data;
        else                                return rf_data;
    endfunction

    assign bus.in_ready = !rst && (!ex_valid_q || bus.ex_ready);
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    // Resolve both source operands against in-flight MEM/WB results
    always_comb begin
        rs1_val = fwd_sel(bus.rs1_addr, bus.rs1_data, bus.fwd_mem_en, bus.fwd_mem_rd,
                          bus.fwd_mem_data, bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
        rs2_val = fwd_sel(bus.rs2_addr, bus.rs2_data, bus.fwd_mem_en, bus.fwd_mem_rd,
                          bus.fwd_mem_data, bus.fwd_wb_en, bus.fwd_wb_rd, bus.fwd_wb_data);
    end

    // Translate opcode/funct3/funct7 into operand selection and ALU op
    always_comb begin
        dec_a   = '0;
        dec_b   = '0;
        dec_op  = ALU_ADD;
        dec_ill = 1'b0;
        unique case (bus.opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec_a = rs1_val;
                dec_b = (bus.opcode == OPC_OP) ? rs2_val : bus.imm;
                unique case (bus.funct3)
                    3'b000: dec_op = (bus.opcode == OPC_OP && bus.funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: dec_op = ALU_SLL;
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_ill = 1'b1;
                    3'b101: begin
                        if (bus.opcode == OPC_OP)
                            dec_op = bus.funct7_5 ? ALU_SRA : ALU_SRL;
                        else
                            dec_op = bus.imm[10] ? ALU_SRA : ALU_SRL;
                    end
                    3'b110: dec_op = ALU_OR;
                    default: dec_op = ALU_AND;
                endcase
                // Immediate shifts carry only the shamt; imm[10] is the arith flag
                if (bus.opcode == OPC_OP_IMM && bus.funct3[1:0] == 2'b01)
                    dec_b = {{(XLEN-5){1'b0}}, bus.imm[4:0]};
            end
            OPC_LOAD, OPC_STORE: begin
                dec_a = rs1_val;
                dec_b = bus.imm;
            end
            OPC_BRANCH: begin
                dec_a = rs1_val;
                dec_b = rs2_val;
                unique case (bus.funct3[2:1])
                    2'b00:   dec_op = ALU_SUB;
                    2'b10:   dec_op = ALU_SLT;
                    2'b11:   dec_op = ALU_SLTU;
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_b = bus.imm;
            end
            OPC_AUIPC: begin
                dec_a = bus.pc;
                dec_b = bus.imm;
            end
            OPC_JAL, OPC_JALR: begin
                dec_a = bus.pc;
                dec_b = XLEN'(4);
            end
            default: dec_ill = 1'b1;
        endcase
        // Unsupported instructions still flow down the pipe but with inert operands
        if (dec_ill) begin
            dec_a  = '0;
            dec_b  = '0;
            dec_op = ALU_ADD;
        end
    end

    // Next-state: load on accept, drop valid on flush or drain, otherwise hold
    always_comb begin
        ex_valid_d = ex_valid_q;
        srca_d     = srca_q;
        srcb_d     = srcb_q;
        alu_op_d   = alu_op_q;
        ex_rd_d    = ex_rd_q;
        ex_pc_d    = ex_pc_q;
        illegal_d  = illegal_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            srca_d     = dec_a;
            srcb_d     = dec_b;
            alu_op_d   = dec_op;
            ex_rd_d    = bus.rd_addr;
            ex_pc_d    = bus.pc;
            illegal_d  = dec_ill;
        end else if (ex_valid_q && bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    // Pipeline register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            srca_q     <= '0;
            srcb_q     <= '0;
            alu_op_q   <= '0;
            ex_rd_q    <= '0;
            ex_pc_q    <= '0;
            illegal_q  <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            srca_q     <= srca_d;
            srcb_q     <= srcb_d;
            alu_op_q   <= alu_op_d;
            ex_rd_q    <= ex_rd_d;
            ex_pc_q    <= ex_pc_d;
            illegal_q  <= illegal_d;
        end
    end

    assign bus.ex_valid = ex_valid_q;
    assign bus.srca     = srca_q;
    assign bus.srcb     = srcb_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.ex_rd    = ex_rd_q;
    assign bus.ex_pc    = ex_pc_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - randomized self-checking bench for alu_operand_stage
module tb_alu_operand_stage;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_operand_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

    alu_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Expected architectural state of the stage output
    logic        e_valid = 1'b0;
    logic        e_known = 1'b0;
    logic [31:0] e_a, e_b, e_pc;
    logic [3:0]  e_op;
    logic [4:0]  e_rd;
    logic        e_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_src(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'd0;
        if (bus.fwd_mem_en && bus.fwd_mem_rd == a) return bus.fwd_mem_data;
        if (bus.fwd_wb_en && bus.fwd_wb_rd == a) return bus.fwd_wb_data;
        return rf;
    endfunction

    // Instruction-level meaning of each supported RV32I form
    task automatic ref_decode(output logic [31:0] a, output logic [31:0] b,
                              output logic [3:0] op, output logic ill);
        logic [31:0] r1, r2;
        logic [2:0]  f3;
        r1 = ref_src(bus.rs1_addr, bus.rs1_data);
        r2 = ref_src(bus.rs2_addr, bus.rs2_data);
        f3 = bus.funct3;
        a = 0; b = 0; op = 4'b0000; ill = 0;
        case (bus.opcode)
            7'b0110011: begin
                a = r1; b = r2;
                case (f3)
                    0: op = bus.funct7_5 ? 4'b0001 : 4'b0000;
                    1: op = 4'b1001;
                    2: op = 4'b1101;
                    3: op = 4'b1111;
                    4: ill = 1;
                    5: op = bus.funct7_5 ? 4'b1010 : 4'b1000;
                    6: op = 4'b0100;
                    7: op = 4'b0101;
                endcase
            end
            7'b0010011: begin
                a = r1; b = bus.imm;
                case (f3)
                    0: op = 4'b0000;
                    1: begin op = 4'b1001; b = bus.imm % 32; end
                    2: op = 4'b1101;
                    3: op = 4'b1111;
                    4: ill = 1;
                    5: begin op = bus.imm[10] ? 4'b1010 : 4'b1000; b = bus.imm % 32; end
                    6: op = 4'b0100;
                    7: op = 4'b0101;
                endcase
            end
            7'b0000011, 7'b0100011: begin a = r1; b = bus.imm; end
            7'b1100011: begin
                a = r1; b = r2;
                if (f3 == 0 || f3 == 1) op = 4'b0001;
                else if (f3 == 4 || f3 == 5) op = 4'b1101;
                else if (f3 == 6 || f3 == 7) op = 4'b1111;
                else ill = 1;
            end
            7'b0110111: b = bus.imm;
            7'b0010111: begin a = bus.pc; b = bus.imm; end
            7'b1101111, 7'b1100111: begin a = bus.pc; b = 4; end
            default: ill = 1;
        endcase
        if (ill) begin a = 0; b = 0; op = 0; end
    endtask

    // One clock: check in_ready, predict the edge, then check all outputs
    task automatic cycle();
        logic rdy, acc, ill;
        logic [31:0] a, b;
        logic [3:0]  op;
        #1;
        rdy = !rst && (!e_valid || bus.ex_ready);
        check("in_ready", bus.in_ready, rdy);
        acc = bus.in_valid && rdy && !bus.flush;
        ref_decode(a, b, op, ill);
        if (rst) begin
            e_valid = 0; e_known = 1;
            e_a = 0; e_b = 0; e_op = 0; e_rd = 0; e_pc = 0; e_ill = 0;
        end else if (bus.flush) begin
            e_valid = 0; e_known = 0;
        end else if (acc) begin
            e_valid = 1; e_known = 1;
            e_a = a; e_b = b; e_op = op; e_rd = bus.rd_addr; e_pc = bus.pc; e_ill = ill;
        end else if (e_valid && bus.ex_ready) begin
            e_valid = 0; e_known = 0;
        end
        @(posedge clk);
        #1;
        check("ex_valid", bus.ex_valid, e_valid);
        if (e_known) begin
            check("srca", bus.srca, e_a);
            check("srcb", bus.srcb, e_b);
            check("alu_op", bus.alu_op, e_op);
            check("ex_rd", bus.ex_rd, e_rd);
            check("ex_pc", bus.ex_pc, e_pc);
            check("illegal", bus.illegal, e_ill);
        end
    endtask

    task automatic set_idle();
        bus.flush = 0; bus.in_valid = 0; bus.ex_ready = 1;
        bus.opcode = 0; bus.funct3 = 0; bus.funct7_5 = 0;
        bus.rs1_addr = 0; bus.rs2_addr = 0; bus.rs1_data = 0; bus.rs2_data = 0;
        bus.imm = 0; bus.pc = 0; bus.rd_addr = 0;
        bus.fwd_mem_en = 0; bus.fwd_mem_rd = 0; bus.fwd_mem_data = 0;
        bus.fwd_wb_en = 0; bus.fwd_wb_rd = 0; bus.fwd_wb_data = 0;
    endtask

    task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input logic [4:0] r1, input logic [4:0] r2,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] im, input logic [31:0] p, input logic [4:0] rd);
        bus.in_valid = 1; bus.opcode = opc; bus.funct3 = f3; bus.funct7_5 = f7;
        bus.rs1_addr = r1; bus.rs2_addr = r2; bus.rs1_data = d1; bus.rs2_data = d2;
        bus.imm = im; bus.pc = p; bus.rd_addr = rd;
    endtask

    logic [6:0] legal_opc [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    initial begin
        set_idle();
        rst = 1;
        cycle();
        cycle();
        rst = 0;

        // OP ADD
        set_instr(7'b0110011, 3'b000, 0, 5'd1, 5'd2, 32'd5, 32'd6, 0, 32'h100, 5'd7);
        cycle();
        check("add_srca", bus.srca, 32'd5);
        check("add_srcb", bus.srcb, 32'd6);
        check("add_op", bus.alu_op, 32'h0);

        // OP-IMM SRAI
        set_instr(7'b0010011, 3'b101, 0, 5'd1, 5'd0, 32'h87654321, 0, 32'h408, 32'h104, 5'd8);
        cycle();
        check("srai_srca", bus.srca, 32'h87654321);
        check("srai_srcb", bus.srcb, 32'd8);
        check("srai_op", bus.alu_op, 32'hA);

        // Forwarding priority
        set_instr(7'b0110011, 3'b000, 0, 5'd3, 5'd0, 32'h1111, 0, 0, 32'h108, 5'd9);
        bus.fwd_mem_en = 1; bus.fwd_mem_rd = 3; bus.fwd_mem_data = 32'hAAAA;
        bus.fwd_wb_en = 1;  bus.fwd_wb_rd = 3;  bus.fwd_wb_data = 32'hBBBB;
        cycle();
        check("fwd_mem", bus.srca, 32'hAAAA);
        bus.fwd_mem_en = 0;
        cycle();
        check("fwd_wb", bus.srca, 32'hBBBB);
        bus.fwd_mem_en = 1; bus.fwd_mem_rd = 0; bus.fwd_wb_rd = 0; bus.rs1_addr = 0;
        cycle();
        check("fwd_x0", bus.srca, 32'h0);
        set_idle();

        // Stall then simultaneous drain and accept
        set_instr(7'b0110011, 3'b000, 1, 5'd1, 5'd2, 32'd50, 32'd8, 0, 32'h200, 5'd4);
        cycle();
        check("sub_op", bus.alu_op, 32'h1);
        bus.ex_ready = 0;
        set_instr(7'b0110011, 3'b110, 0, 5'd1, 5'd2, 32'd1, 32'd2, 0, 32'h204, 5'd5);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_pc", bus.ex_pc, 32'h200);
        end
        bus.ex_ready = 1;
        cycle();
        check("reload_op", bus.alu_op, 32'h4);
        check("reload_valid", bus.ex_valid, 1);

        // Flush wins over accept
        bus.flush = 1;
        set_instr(7'b0110011, 3'b111, 0, 5'd1, 5'd2, 32'd3, 32'd4, 0, 32'h300, 5'd6);
        cycle();
        check("flush_valid", bus.ex_valid, 0);
        bus.flush = 0;

        // Reset mid-stall
        cycle();
        bus.ex_ready = 0; bus.in_valid = 0;
        cycle();
        rst = 1;
        cycle();
        check("rst_srca", bus.srca, 0);
        rst = 0;
        bus.ex_ready = 1;

        // Illegal XOR, then LUI
        set_instr(7'b0110011, 3'b100, 0, 5'd1, 5'd2, 32'd9, 32'd9, 0, 32'h400, 5'd1);
        cycle();
        check("xor_ill", bus.illegal, 1);
        check("xor_srcb", bus.srcb, 0);
        set_instr(7'b0110111, 3'b000, 0, 5'd0, 5'd0, 0, 0, 32'h12345000, 32'h404, 5'd2);
        cycle();
        check("lui_srcb", bus.srcb, 32'h12345000);
        check("lui_ill", bus.illegal, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.ex_ready = ($urandom_range(0, 2) != 0);
            bus.opcode = ($urandom_range(0, 9) == 0) ? 7'($urandom) : legal_opc[$urandom_range(0, 8)];
            bus.funct3 = 3'($urandom);
            bus.funct7_5 = 1'($urandom);
            bus.rs1_addr = 5'($urandom_range(0, 3));
            bus.rs2_addr = 5'($urandom_range(0, 3));
            bus.rs1_data = $urandom;
            bus.rs2_data = $urandom;
            bus.imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 2047));
            bus.pc = $urandom;
            bus.rd_addr = 5'($urandom);
            bus.fwd_mem_en = 1'($urandom);
            bus.fwd_mem_rd = 5'($urandom_range(0, 3));
            bus.fwd_mem_data = $urandom;
            bus.fwd_wb_en = 1'($urandom);
            bus.fwd_wb_rd = 5'($urandom_range(0, 3));
            bus.fwd_wb_data = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
